// File: rtl/nibbler_pkg.sv
// Shared types for the nibbler fetch path: address width,
// opcode map and fetch FSM states.
package nibbler_pkg;

    localparam int ADDR_W = 12;

    typedef enum logic [3:0] {
        OP_JC   = 4'h0,
        OP_JNC  = 4'h1,
        OP_JZ   = 4'h2,
        OP_JNZ  = 4'h3,
        OP_JMP  = 4'h4,
        OP_GEN5 = 4'h5,
        OP_GEN6 = 4'h6,
        OP_GEN7 = 4'h7,
        OP_GEN8 = 4'h8,
        OP_GEN9 = 4'h9,
        OP_GENA = 4'hA,
        OP_GENB = 4'hB,
        OP_GENC = 4'hC,
        OP_GEND = 4'hD,
        OP_GENE = 4'hE,
        OP_GENF = 4'hF
    } opcode_t;

    typedef enum logic {
        FETCH1 = 1'b0,
        FETCH2 = 1'b1
    } fetch_state_t;

    function automatic logic is_jump(logic [3:0] op);
        return op <= 4'(OP_JMP);
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Jump condition evaluation from the latched jump opcode
// and the live ALU flags.
module branch_cond
    import nibbler_pkg::*;
(
    input  logic [3:0] jop,
    input  logic       carry_flag,
    input  logic       zero_flag,
    output logic       taken
);

    opcode_t op;

    assign op = opcode_t'(jop);

    always_comb begin
        taken = 1'b0;
        unique case (1'b1)
            (op == OP_JC):  taken = carry_flag;
            (op == OP_JNC): taken = ~carry_flag;
            (op == OP_JZ):  taken = zero_flag;
            (op == OP_JNZ): taken = ~zero_flag;
            (op == OP_JMP): taken = 1'b1;
            default:        taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Two-state instruction fetch sequencer: issues single-byte
// instructions and drives PC load/increment for two-byte jumps.
module fetch_sequencer
    import nibbler_pkg::*;
#(
    parameter int N = ADDR_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   rom_data,
    input  logic         carry_flag,
    input  logic         zero_flag,
    input  logic         stall,
    output logic         notLoadPC,
    output logic         incPC,
    output logic [N-1:0] loadAddress,
    output logic         instr_valid,
    output logic [3:0]   opcode,
    output logic [3:0]   operand
);

    fetch_state_t state;
    logic [3:0]   hi_nibble;
    logic [3:0]   jop;
    logic [3:0]   op_in;
    logic         taken;

    assign op_in = rom_data[7:4];

    branch_cond u_cond (
        .jop        (jop),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .taken      (taken)
    );

    assign loadAddress = N'({hi_nibble, rom_data});

    // Strobes are combinational so the PC acts on the same edge.
    always_comb begin
        incPC     = 1'b0;
        notLoadPC = 1'b1;
        if (!reset && !stall) begin
            if (state == FETCH1) begin
                incPC = 1'b1;
            end else if (taken) begin
                notLoadPC = 1'b0;
            end else begin
                incPC = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FETCH1;
            hi_nibble   <= 4'h0;
            jop         <= 4'h0;
            instr_valid <= 1'b0;
            opcode      <= 4'h0;
            operand     <= 4'h0;
        end else if (stall) begin
            instr_valid <= 1'b0;
        end else begin
            unique case (state)
                FETCH1: begin
                    if (is_jump(op_in)) begin
                        jop         <= op_in;
                        hi_nibble   <= rom_data[3:0];
                        instr_valid <= 1'b0;
                        state       <= FETCH2;
                    end else begin
                        opcode      <= op_in;
                        operand     <= rom_data[3:0];
                        instr_valid <= 1'b1;
                    end
                end
                FETCH2: begin
                    instr_valid <= 1'b0;
                    state       <= FETCH1;
                end
                default: state <= FETCH1;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench: fetch_sequencer with a program counter and ROM,
// checked every cycle against a byte-level program model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rom_data;
    logic        carry_flag = 1'b0;
    logic        zero_flag = 1'b0;
    logic        stall = 1'b0;
    logic        notLoadPC;
    logic        incPC;
    logic [11:0] loadAddress;
    logic        instr_valid;
    logic [3:0]  opcode;
    logic [3:0]  operand;

    logic [7:0]  rom [0:4095];
    logic [11:0] pc;
    logic        preset_req = 1'b0;
    logic [11:0] preset_val = 12'h0;

    int n_vec = 0;
    int n_err = 0;

    fetch_sequencer #(.N(12)) dut (
        .clk         (clk),
        .reset       (reset),
        .rom_data    (rom_data),
        .carry_flag  (carry_flag),
        .zero_flag   (zero_flag),
        .stall       (stall),
        .notLoadPC   (notLoadPC),
        .incPC       (incPC),
        .loadAddress (loadAddress),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .operand     (operand)
    );

    always #5 clk = ~clk;

    // Program counter paired with the sequencer
    always @(posedge clk or posedge reset) begin
        if (reset)           pc <= 12'h000;
        else if (preset_req) pc <= preset_val;
        else if (!notLoadPC) pc <= loadAddress;
        else if (incPC)      pc <= pc + 12'h001;
    end

    assign rom_data = rom[pc];

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Program model: where the program is, whether half a jump
    // has been read, and what the last issued instruction was.
    logic [11:0] mpc, n_mpc;
    logic        mj, n_mj;
    logic [3:0]  mjop, n_mjop, mhi, n_mhi;
    logic        mv, n_mv;
    logic [3:0]  mop, n_mop, mopd, n_mopd;

    always @(negedge clk) begin
        logic [7:0]  b;
        logic [11:0] tgt;
        logic        tk, e_inc, e_nl;
        b   = rom[mpc];
        tgt = {mhi, b};
        check("pc", pc, mpc);
        check("instr_valid", instr_valid, mv);
        check("opcode", opcode, mop);
        check("operand", operand, mopd);
        n_mpc = mpc; n_mj = mj; n_mjop = mjop; n_mhi = mhi;
        n_mv = 1'b0; n_mop = mop; n_mopd = mopd;
        tk = 1'b0;
        case (mjop)
            4'h0: tk = carry_flag;
            4'h1: tk = !carry_flag;
            4'h2: tk = zero_flag;
            4'h3: tk = !zero_flag;
            4'h4: tk = 1'b1;
            default: tk = 1'b0;
        endcase
        e_inc = 1'b0;
        e_nl  = 1'b1;
        if (reset) begin
            n_mpc = 12'h0; n_mj = 1'b0; n_mop = 4'h0; n_mopd = 4'h0;
        end else if (stall) begin
            e_inc = 1'b0;
        end else if (!mj) begin
            e_inc = 1'b1;
            n_mpc = mpc + 12'h001;
            if (b[7:4] <= 4'h4) begin
                n_mj = 1'b1; n_mjop = b[7:4]; n_mhi = b[3:0];
            end else begin
                n_mv = 1'b1; n_mop = b[7:4]; n_mopd = b[3:0];
            end
        end else begin
            n_mj = 1'b0;
            if (tk) begin
                e_nl  = 1'b0;
                n_mpc = tgt;
                check("loadAddress", loadAddress, tgt);
            end else begin
                e_inc = 1'b1;
                n_mpc = mpc + 12'h001;
            end
        end
        check("incPC", incPC, e_inc);
        check("notLoadPC", notLoadPC, e_nl);
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mpc <= 12'h0; mj <= 1'b0; mjop <= 4'h0; mhi <= 4'h0;
            mv <= 1'b0; mop <= 4'h0; mopd <= 4'h0;
        end else begin
            mpc  <= preset_req ? preset_val : n_mpc;
            mj   <= n_mj;
            mjop <= n_mjop;
            mhi  <= n_mhi;
            mv   <= n_mv;
            mop  <= n_mop;
            mopd <= n_mopd;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic preset(input logic [11:0] a);
        stall      = 1'b1;
        preset_val = a;
        preset_req = 1'b1;
        tick();
        preset_req = 1'b0;
        stall      = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 8'hF0;
        #1 reset = 1'b1;
        #1;
        check("rst_valid", instr_valid, 0);
        check("rst_opcode", opcode, 0);
        check("rst_operand", operand, 0);
        check("rst_inc", incPC, 0);
        check("rst_nload", notLoadPC, 1);
        check("rst_pc", pc, 0);

        // three single-byte instructions back to back
        rom[0] = 8'h57; rom[1] = 8'h6A; rom[2] = 8'h8F;
        do_reset();
        tick();
        check("seq0_v", instr_valid, 1);
        check("seq0_op", {opcode, operand}, 8'h57);
        tick();
        check("seq1_v", instr_valid, 1);
        check("seq1_op", {opcode, operand}, 8'h6A);
        tick();
        check("seq2_v", instr_valid, 1);
        check("seq2_op", {opcode, operand}, 8'h8F);
        check("seq_pc", pc, 12'h003);

        // JMP 0x123
        rom[0] = 8'h41; rom[1] = 8'h23;
        do_reset();
        tick();
        check("jmp_f2_pc", pc, 12'h001);
        check("jmp_nload", notLoadPC, 0);
        check("jmp_inc", incPC, 0);
        check("jmp_addr", loadAddress, 12'h123);
        tick();
        check("jmp_pc", pc, 12'h123);
        check("jmp_valid", instr_valid, 0);

        // JZ 0x0F0, not taken then taken
        rom[0] = 8'h20; rom[1] = 8'hF0;
        zero_flag = 1'b0;
        do_reset();
        carry_flag = 1'b1;
        tick();
        check("jz_nt_nload", notLoadPC, 1);
        tick();
        check("jz_nt_pc", pc, 12'h002);
        zero_flag  = 1'b1;
        carry_flag = 1'b0;
        do_reset();
        tick();
        tick();
        check("jz_t_pc", pc, 12'h0F0);

        // JC 0xABC stalled three cycles in FETCH2
        rom[0] = 8'h0A; rom[1] = 8'hBC;
        carry_flag = 1'b1;
        zero_flag  = 1'b0;
        do_reset();
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_inc", incPC, 0);
            check("stall_nload", notLoadPC, 1);
            tick();
            check("stall_pc", pc, 12'h001);
        end
        stall = 1'b0;
        #1;
        check("jc_nload", notLoadPC, 0);
        tick();
        check("jc_pc", pc, 12'hABC);

        // reset in the middle of a FETCH2 cycle
        rom[0] = 8'h41; rom[1] = 8'h23;
        do_reset();
        tick();
        #1 reset = 1'b1;
        #1;
        check("mid_valid", instr_valid, 0);
        check("mid_inc", incPC, 0);
        check("mid_nload", notLoadPC, 1);
        check("mid_pc", pc, 12'h000);
        tick();
        reset = 1'b0;
        tick();
        check("restart_pc", pc, 12'h001);
        check("restart_nload", notLoadPC, 0);

        // single-byte instruction at the top of memory
        rom[12'hFFF] = 8'h50; rom[0] = 8'hF0;
        do_reset();
        preset(12'hFFF);
        check("wrap_start", pc, 12'hFFF);
        tick();
        check("wrap_v", instr_valid, 1);
        check("wrap_op", {opcode, operand}, 8'h50);
        check("wrap_pc", pc, 12'h000);

        // jump whose second byte sits across the wrap
        rom[12'hFFF] = 8'h41; rom[0] = 8'h23;
        preset(12'hFFF);
        tick();
        check("wjmp_f2_pc", pc, 12'h000);
        tick();
        check("wjmp_pc", pc, 12'h123);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
